// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver (master) presents data_out/data_valid; the consumer (slave)
// answers with data_ready. A byte is consumed on a cycle where both are high.
interface uart_rx_if;
   logic [7:0] data_out;
   logic       data_valid;
   logic       data_ready;

   modport master (output data_out, output data_valid, input data_ready);
   modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a valid/ready byte output.
// rx_io is double-flopped into the clk domain. Each start edge is confirmed
// at half a bit time, and every later bit is sampled one full bit time apart.
// A stop bit that samples low raises a one-cycle frame_error pulse and the
// byte is dropped. The receiver re-arms only after the line has been seen high.
// Optional feature: define UART_RX_OVERRUN_EN to keep the unconsumed byte and
// raise a sticky overrun flag. Without it, a new byte overwrites data_out.
module uart_rx #(
   parameter int CLK_FREQ  = 50_000_000,
   parameter int BAUD_RATE = 115200
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      rx_io,
   uart_rx_if.master rx_bus,
   output logic      frame_error,
   output logic      overrun,
   output logic      busy
);

   localparam int          CLK_PER_BIT  = CLK_FREQ / BAUD_RATE;
   localparam int          HALF_BIT     = CLK_PER_BIT / 2;
   localparam logic [11:0] LP_BIT_LAST  = 12'(CLK_PER_BIT - 1);
   localparam logic [11:0] LP_HALF_LAST = 12'(HALF_BIT - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic [1:0]  r_sync;
   logic        w_rx_s;
   logic [11:0] r_cnt;
   logic [2:0]  r_idx;
   logic [7:0]  r_shift;
   logic        r_armed;
   logic [7:0]  r_data_out;
   logic        r_data_valid;
   logic        r_frame_error;
   logic        w_cnt_clr;
   logic        w_sample_bit;
   logic        w_stop_tick;
   logic        w_deliver;
   logic        w_handshake;

   assign w_rx_s      = r_sync[1];
   assign w_deliver   = w_stop_tick & w_rx_s;
   assign w_handshake = r_data_valid & rx_bus.data_ready;

   assign rx_bus.data_out   = r_data_out;
   assign rx_bus.data_valid = r_data_valid;
   assign frame_error       = r_frame_error;
   assign busy              = (r_state != S_IDLE);

   // Two-flop synchronizer for the asynchronous serial line; idles high.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= 2'b11;
      else        r_sync <= {r_sync[0], rx_io};
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Next-state logic and the bit-timing strobes.
   always_comb begin
      w_state_nxt  = r_state;
      w_cnt_clr    = 1'b0;
      w_sample_bit = 1'b0;
      w_stop_tick  = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_cnt_clr = 1'b1;
            if (r_armed && !w_rx_s) w_state_nxt = S_START;
         end
         S_START: begin
            if (r_cnt == LP_HALF_LAST) begin
               w_cnt_clr   = 1'b1;
               w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (r_cnt == LP_BIT_LAST) begin
               w_cnt_clr    = 1'b1;
               w_sample_bit = 1'b1;
               if (r_idx == 3'd7) w_state_nxt = S_STOP;
            end
         end
         S_STOP: begin
            if (r_cnt == LP_BIT_LAST) begin
               w_cnt_clr   = 1'b1;
               w_stop_tick = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bit timer, bit index, shift register and the idle re-arm flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt   <= 12'd0;
         r_idx   <= 3'd0;
         r_shift <= 8'h00;
         r_armed <= 1'b0;
      end else begin
         r_cnt <= w_cnt_clr ? 12'd0 : r_cnt + 12'd1;
         if (r_state == S_START)  r_idx <= 3'd0;
         else if (w_sample_bit)   r_idx <= r_idx + 3'd1;
         if (w_sample_bit) r_shift[r_idx] <= w_rx_s;
         // Arm only once the line is seen high in IDLE, so a held break never retriggers.
         if (r_state != S_IDLE) r_armed <= 1'b0;
         else if (w_rx_s)       r_armed <= 1'b1;
      end
   end

   // Frame error pulse: asserted for the single cycle after a low stop sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_frame_error <= 1'b0;
      else        r_frame_error <= w_stop_tick & ~w_rx_s;
   end

`ifdef UART_RX_OVERRUN_EN
   logic r_overrun;
   logic w_blocked;

   assign w_blocked = r_data_valid & ~rx_bus.data_ready;
   assign overrun   = r_overrun;

   // Output register: a byte arriving while the old one is still waiting is dropped and flagged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
         r_overrun    <= 1'b0;
      end else begin
         if (w_deliver && w_blocked) r_overrun <= 1'b1;
         else if (w_handshake)       r_overrun <= 1'b0;
         if (w_deliver && !w_blocked) begin
            r_data_out   <= r_shift;
            r_data_valid <= 1'b1;
         end else if (w_handshake) begin
            r_data_valid <= 1'b0;
         end
      end
   end
`else
   assign overrun = 1'b0;

   // Output register: the newest byte always wins, even if the last one was not taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_data_out   <= 8'h00;
         r_data_valid <= 1'b0;
      end else if (w_deliver) begin
         r_data_out   <= r_shift;
         r_data_valid <= 1'b1;
      end else if (w_handshake) begin
         r_data_valid <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx at 50 MHz / 115200 baud (434 clocks per bit).
// Frames are driven bit by bit on rx_io. The reference model is a queue of
// bytes the consumer should receive, in order; it also tracks the last byte
// that data_out must hold. Honours UART_RX_OVERRUN_EN like the design.
module tb_uart_rx;

   localparam int CPB = 50_000_000 / 115200;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rx_io = 1'b1;
   logic frame_error;
   logic overrun;
   logic busy;

   uart_rx_if bus ();

   uart_rx #(.CLK_FREQ(50_000_000), .BAUD_RATE(115200)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx_io       (rx_io),
      .rx_bus      (bus),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   // 50 MHz clock.
   always #10 clk = ~clk;

   int         n_checks = 0;
   int         n_pass   = 0;
   logic [7:0] got[$];
   logic [7:0] exp_q[$];
   logic [7:0] model_last = 8'h00;
   int         fe_cnt = 0;
   int         vcnt   = 0;

   // Observer on the falling edge: consumed bytes, frame_error cycles, valid cycles.
   always @(negedge clk) begin
      if (rst_n && bus.data_valid && bus.data_ready) got.push_back(bus.data_out);
      if (frame_error)    fe_cnt++;
      if (bus.data_valid) vcnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_obs();
      got.delete();
      exp_q.delete();
      fe_cnt = 0;
      vcnt   = 0;
   endtask

   task automatic send_body(input logic [7:0] b);
      rx_io = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         rx_io = b[i];
         tick(CPB);
      end
   endtask

   // Full frame; a good frame is added to the model of consumed bytes.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      send_body(b);
      rx_io = stop;
      tick(CPB);
      rx_io = 1'b1;
      if (stop) begin
         exp_q.push_back(b);
         model_last = b;
      end
   endtask

   task automatic compare_queue(input string tag);
      n_checks++;
      if (got.size() !== exp_q.size())
         $display("FAIL %s_count: got %0d bytes, expected %0d", tag, got.size(), exp_q.size());
      else n_pass++;
      for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
         n_checks++;
         if (got[i] !== exp_q[i])
            $display("FAIL %s_byte%0d: got %02h expected %02h", tag, i, got[i], exp_q[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(4);
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL rst_data_out: got %02h expected 00", bus.data_out); else n_pass++;
      n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL rst_data_valid: got %b expected 0", bus.data_valid); else n_pass++;
      n_checks++; if (frame_error !== 1'b0) $display("FAIL rst_frame_error: got %b expected 0", frame_error); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL rst_overrun: got %b expected 0", overrun); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy); else n_pass++;
      rst_n = 1'b1;
      tick(10);
   endtask

   task automatic test_single();
      clear_obs();
      send_frame(8'hA5, 1'b1);
      tick(2 * CPB);
      compare_queue("single");
      n_checks++; if (vcnt !== 1) $display("FAIL single_valid_cycles: got %0d expected 1", vcnt); else n_pass++;
      n_checks++; if (fe_cnt !== 0) $display("FAIL single_frame_error: got %0d expected 0", fe_cnt); else n_pass++;
      n_checks++; if (bus.data_out !== model_last) $display("FAIL single_hold: got %02h expected %02h", bus.data_out, model_last); else n_pass++;
   endtask

   task automatic test_frame_error();
      clear_obs();
      send_body(8'h3C);
      rx_io = 1'b0;
      tick(6 * CPB);
      n_checks++; if (busy !== 1'b0) $display("FAIL break_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (fe_cnt !== 1) $display("FAIL break_fe_pulses: got %0d expected 1", fe_cnt); else n_pass++;
      n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL break_valid: got %b expected 0", bus.data_valid); else n_pass++;
      n_checks++; if (bus.data_out !== model_last) $display("FAIL break_hold: got %02h expected %02h", bus.data_out, model_last); else n_pass++;
      rx_io = 1'b1;
      tick(CPB);
      send_frame(8'h81, 1'b1);
      tick(2 * CPB);
      compare_queue("after_break");
      n_checks++; if (fe_cnt !== 1) $display("FAIL after_break_fe: got %0d expected 1", fe_cnt); else n_pass++;
   endtask

   task automatic test_glitch();
      clear_obs();
      rx_io = 1'b0;
      tick(50);
      n_checks++; if (busy !== 1'b1) $display("FAIL glitch_busy_start: got %b expected 1", busy); else n_pass++;
      tick(50);
      rx_io = 1'b1;
      tick(300);
      n_checks++; if (busy !== 1'b0) $display("FAIL glitch_busy_end: got %b expected 0", busy); else n_pass++;
      n_checks++; if (vcnt !== 0) $display("FAIL glitch_valid: got %0d cycles expected 0", vcnt); else n_pass++;
      n_checks++; if (fe_cnt !== 0) $display("FAIL glitch_fe: got %0d expected 0", fe_cnt); else n_pass++;
   endtask

   task automatic test_overrun();
      logic [7:0] exp_data;
      logic       exp_ovr;
      clear_obs();
      bus.data_ready = 1'b0;
      send_frame(8'h11, 1'b1);
      tick(CPB);
      send_frame(8'h22, 1'b1);
      tick(2 * CPB);
`ifdef UART_RX_OVERRUN_EN
      exp_data = 8'h11;
      exp_ovr  = 1'b1;
`else
      exp_data = 8'h22;
      exp_ovr  = 1'b0;
`endif
      model_last = exp_data;
      n_checks++; if (bus.data_valid !== 1'b1) $display("FAIL ovr_valid: got %b expected 1", bus.data_valid); else n_pass++;
      n_checks++; if (bus.data_out !== exp_data) $display("FAIL ovr_data: got %02h expected %02h", bus.data_out, exp_data); else n_pass++;
      n_checks++; if (overrun !== exp_ovr) $display("FAIL ovr_flag: got %b expected %b", overrun, exp_ovr); else n_pass++;
      bus.data_ready = 1'b1;
      tick(4);
      exp_q.delete();
      exp_q.push_back(exp_data);
      compare_queue("ovr_accept");
      n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL ovr_valid_drop: got %b expected 0", bus.data_valid); else n_pass++;
      n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_clear: got %b expected 0", overrun); else n_pass++;
   endtask

   task automatic test_back_to_back();
      clear_obs();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h55, 1'b1);
      tick(2 * CPB);
      compare_queue("b2b");
      n_checks++; if (vcnt !== 3) $display("FAIL b2b_valid_cycles: got %0d expected 3", vcnt); else n_pass++;
   endtask

   task automatic test_random();
      logic [7:0] b;
      clear_obs();
      for (int k = 0; k < 3; k++) begin
         b = 8'($urandom);
         send_frame(b, 1'b1);
         tick($urandom_range(0, CPB));
      end
      tick(2 * CPB);
      compare_queue("random");
      n_checks++; if (vcnt !== exp_q.size()) $display("FAIL random_valid_cycles: got %0d expected %0d", vcnt, exp_q.size()); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      clear_obs();
      b = 8'h5A;
      rx_io = 1'b0;
      tick(CPB);
      for (int i = 0; i < 4; i++) begin
         rx_io = b[i];
         tick(CPB);
      end
      rst_n = 1'b0;
      tick(2);
      n_checks++; if (bus.data_out !== 8'h00) $display("FAIL mid_rst_data_out: got %02h expected 00", bus.data_out); else n_pass++;
      n_checks++; if (bus.data_valid !== 1'b0) $display("FAIL mid_rst_valid: got %b expected 0", bus.data_valid); else n_pass++;
      n_checks++; if (busy !== 1'b0) $display("FAIL mid_rst_busy: got %b expected 0", busy); else n_pass++;
      n_checks++; if (frame_error !== 1'b0 || overrun !== 1'b0) $display("FAIL mid_rst_flags: got %b%b expected 00", frame_error, overrun); else n_pass++;
      for (int i = 4; i < 8; i++) begin
         rx_io = b[i];
         tick(CPB);
      end
      rx_io = 1'b1;
      tick(CPB);
      rst_n = 1'b1;
      tick(CPB);
      n_checks++; if (bus.data_valid !== 1'b0 || got.size() != 0) $display("FAIL mid_rst_quiet: valid %b bytes %0d expected 0 and 0", bus.data_valid, got.size()); else n_pass++;
      model_last = 8'h00;
      send_frame(8'hC3, 1'b1);
      tick(2 * CPB);
      compare_queue("after_reset");
      n_checks++; if (fe_cnt !== 0) $display("FAIL after_reset_fe: got %0d expected 0", fe_cnt); else n_pass++;
   endtask

   initial begin
      bus.data_ready = 1'b1;
      test_reset();
      test_single();
      test_frame_error();
      test_glitch();
      test_overrun();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
